// File: rtl/gray_counter_conv.sv
// Up/down binary+Gray counter with load, plus an independent bin<->Gray converter.
// Counter updates each edge; converter result appears one cycle after the request, no back-pressure.
module gray_counter_conv #(
    parameter int WIDTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_up_dn,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_bin,
    output logic [WIDTH-1:0] o_gray,
    output logic             o_tc,
    input  logic             i_conv_valid,
    input  logic             i_conv_mode,
    input  logic [WIDTH-1:0] i_conv_in,
    output logic [WIDTH-1:0] o_conv_out,
    output logic             o_conv_out_valid
);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic [WIDTH-1:0] r_conv_out;
    logic             r_conv_out_valid;

    logic [WIDTH-1:0] w_bin_nxt;
    logic [WIDTH-1:0] w_gray_nxt;
    logic [WIDTH-1:0] w_b2g;
    logic [WIDTH-1:0] w_g2b;

    always_comb begin
        w_bin_nxt = r_bin;
        if (i_load) begin
            w_bin_nxt = i_load_val;
        end else if (i_en) begin
            w_bin_nxt = i_up_dn ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));
        end
    end

    // Gray is encoded from the next binary value so both registers move on the same edge.
    assign w_gray_nxt = w_bin_nxt ^ (w_bin_nxt >> 1);

    assign w_b2g = i_conv_in ^ (i_conv_in >> 1);

    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        w_g2b = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_g2b[i] = ^(i_conv_in >> i);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin  <= '0;
            r_gray <= '0;
        end else begin
            r_bin  <= w_bin_nxt;
            r_gray <= w_gray_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_conv_out       <= '0;
            r_conv_out_valid <= 1'b0;
        end else begin
            r_conv_out_valid <= i_conv_valid;
            if (i_conv_valid) begin
                r_conv_out <= i_conv_mode ? w_g2b : w_b2g;
            end
        end
    end

    assign o_bin            = r_bin;
    assign o_gray           = r_gray;
    assign o_tc             = (i_up_dn && (r_bin == '1)) || (!i_up_dn && (r_bin == '0));
    assign o_conv_out       = r_conv_out;
    assign o_conv_out_valid = r_conv_out_valid;

endmodule
